// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : camera_pkg
//  Description : Shared types and constants for the camera/player pose host.
//                Holds the FSM state encoding, the rotate/move command
//                encodings, the default build parameters, the pose record
//                for the default build, and the trig helper used to fill
//                the heading ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    // Default build parameters
    localparam int DEF_COORD_W  = 10;
    localparam int DEF_H_W      = 8;
    localparam int DEF_DIR_W    = 8;
    localparam int DEF_HEADINGS = 16;
    localparam int DEF_SPEED    = 4;
    localparam int DEF_TICK_DIV = 8;
    localparam int DEF_X_MAX    = 1023;
    localparam int DEF_Y_MAX    = 767;
    localparam int DEF_X_INIT   = 512;
    localparam int DEF_Y_INIT   = 384;
    localparam int DEF_H_INIT   = 64;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ROT    = 2'd1;
    localparam state_t ST_LOOKUP = 2'd2;
    localparam state_t ST_MOVE   = 2'd3;

    // Command encodings; 00 and 11 mean "no action" for both inputs
    localparam logic [1:0] ROT_CCW  = 2'b01;
    localparam logic [1:0] ROT_CW   = 2'b10;
    localparam logic [1:0] MOVE_BWD = 2'b01;
    localparam logic [1:0] MOVE_FWD = 2'b10;

    // Pose record sized for the default build
    typedef struct packed {
        logic        [DEF_COORD_W-1:0]          x;
        logic        [DEF_COORD_W-1:0]          y;
        logic        [DEF_H_W-1:0]              h;
        logic        [$clog2(DEF_HEADINGS)-1:0] heading;
        logic signed [DEF_DIR_W-1:0]            dir_x;
        logic signed [DEF_DIR_W-1:0]            dir_y;
    } pose_t;

    localparam real C_PI = 3.14159265358979323846;

    // round(2^(dir_w-2) * cos/sin(2*pi*k/n)), rounding half away from zero.
    // Only ever evaluated on constants at elaboration time.
    function automatic int trig_entry(input int k, input int n, input int dir_w,
                                      input bit is_sin);
        real ang;
        real v;
        ang = 2.0 * C_PI * real'(k) / real'(n);
        v   = (is_sin ? $sin(ang) : $cos(ang)) * real'(1 << (dir_w - 2));
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return -$rtoi(0.5 - v);
    endfunction

    function automatic logic cmd_active(input logic [1:0] cmd);
        return (cmd == 2'b01) || (cmd == 2'b10);
    endfunction

endpackage : camera_pkg
`default_nettype wire

// File: rtl/heading_rom.sv
`default_nettype none
// ============================================================================
//  Module      : heading_rom
//  Description : Registered cos/sin table, HEADINGS entries of DIR_W signed
//                bits each, scaled so that unit length is 2^(DIR_W-2).
//                One-cycle read latency.
//  Ports       : clk     - clock
//                rst     - asynchronous active-high reset (output -> entry 0)
//                addr_i  - heading index
//                cos_o   - cos entry for the address of the previous edge
//                sin_o   - sin entry for the address of the previous edge
//  Revision    : 1.0 - initial release
// ============================================================================
module heading_rom
    import camera_pkg::*;
#(
    parameter int HEADINGS = DEF_HEADINGS,
    parameter int DIR_W    = DEF_DIR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(HEADINGS)-1:0] addr_i,
    output logic signed [DIR_W-1:0]     cos_o,
    output logic signed [DIR_W-1:0]     sin_o
);

    logic signed [DIR_W-1:0] w_cos_tab [HEADINGS];
    logic signed [DIR_W-1:0] w_sin_tab [HEADINGS];

    for (genvar k = 0; k < HEADINGS; k++) begin : g_tab
        assign w_cos_tab[k] = DIR_W'(trig_entry(k, HEADINGS, DIR_W, 1'b0));
        assign w_sin_tab[k] = DIR_W'(trig_entry(k, HEADINGS, DIR_W, 1'b1));
    end

    logic signed [DIR_W-1:0] cos_q;
    logic signed [DIR_W-1:0] sin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_q <= w_cos_tab[0];
            sin_q <= w_sin_tab[0];
        end else begin
            cos_q <= w_cos_tab[addr_i];
            sin_q <= w_sin_tab[addr_i];
        end
    end

    assign cos_o = cos_q;
    assign sin_o = sin_q;

endmodule : heading_rom
`default_nettype wire

// File: rtl/camera_host.sv
`default_nettype none
// ============================================================================
//  Module      : camera_host
//  Description : Camera/player pose host. Samples rotate/move once every
//                TICK_DIV cycles, steps a quantised heading, fetches its
//                direction vector from heading_rom, moves the player with
//                clamping, and publishes a frame-stable pose snapshot only
//                at frame boundaries.
//  Ports       : clk, rst             - clock, async active-high reset
//                rotate, move         - 2-bit control commands
//                frame_req            - frame boundary pulse from renderer
//                pose_valid           - 1-cycle pulse when pub_* update
//                pub_x/y/h            - published position and height
//                pub_dir_x/y          - published signed direction vector
//                pub_heading          - published heading index
//  Revision    : 1.0 - initial release
// ============================================================================
module camera_host
    import camera_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int H_W      = DEF_H_W,
    parameter int DIR_W    = DEF_DIR_W,
    parameter int HEADINGS = DEF_HEADINGS,
    parameter int SPEED    = DEF_SPEED,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int Y_MAX    = DEF_Y_MAX,
    parameter int X_INIT   = DEF_X_INIT,
    parameter int Y_INIT   = DEF_Y_INIT,
    parameter int H_INIT   = DEF_H_INIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  rotate,
    input  logic [1:0]                  move,
    input  logic                        frame_req,
    output logic                        pose_valid,
    output logic [COORD_W-1:0]          pub_x,
    output logic [COORD_W-1:0]          pub_y,
    output logic [H_W-1:0]              pub_h,
    output logic signed [DIR_W-1:0]     pub_dir_x,
    output logic signed [DIR_W-1:0]     pub_dir_y,
    output logic [$clog2(HEADINGS)-1:0] pub_heading
);

    localparam int HD_W   = $clog2(HEADINGS);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int PW     = COORD_W + 2;   // signed width for position math
    localparam int SHIFT  = DIR_W - 2;

    localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic signed [DIR_W-1:0] DIR_UNIT = DIR_W'(2 ** (DIR_W - 2));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic [TICK_W-1:0]       tick_q,      tick_d;
    logic [1:0]              rot_cmd_q,   rot_cmd_d;
    logic [1:0]              mov_cmd_q,   mov_cmd_d;
    logic                    pending_q,   pending_d;

    // Shadow pose
    logic [COORD_W-1:0]      x_q,         x_d;
    logic [COORD_W-1:0]      y_q,         y_d;
    logic [HD_W-1:0]         heading_q,   heading_d;
    logic signed [DIR_W-1:0] dir_x_q,     dir_x_d;
    logic signed [DIR_W-1:0] dir_y_q,     dir_y_d;

    // Published pose
    logic                    pose_valid_q, pose_valid_d;
    logic [COORD_W-1:0]      pub_x_q,     pub_x_d;
    logic [COORD_W-1:0]      pub_y_q,     pub_y_d;
    logic [HD_W-1:0]         pub_hd_q,    pub_hd_d;
    logic signed [DIR_W-1:0] pub_dx_q,    pub_dx_d;
    logic signed [DIR_W-1:0] pub_dy_q,    pub_dy_d;

    // ------------------------------------------------------------------
    // Direction ROM. Addressed with the next heading so that the entry for
    // the freshly rotated heading is already on the ROM output during
    // LOOKUP, letting the dir registers load at the end of that cycle.
    // ------------------------------------------------------------------
    logic signed [DIR_W-1:0] w_rom_cos;
    logic signed [DIR_W-1:0] w_rom_sin;

    heading_rom #(
        .HEADINGS (HEADINGS),
        .DIR_W    (DIR_W)
    ) u_heading_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (heading_d),
        .cos_o  (w_rom_cos),
        .sin_o  (w_rom_sin)
    );

    // ------------------------------------------------------------------
    // Movement step: (dir * SPEED) >>> SHIFT, floor via arithmetic shift
    // ------------------------------------------------------------------
    logic signed [PW-1:0] w_step_x;
    logic signed [PW-1:0] w_step_y;
    logic signed [PW-1:0] w_pos_x;
    logic signed [PW-1:0] w_pos_y;

    assign w_step_x = (PW'(dir_x_q) * PW'(SPEED)) >>> SHIFT;
    assign w_step_y = (PW'(dir_y_q) * PW'(SPEED)) >>> SHIFT;
    assign w_pos_x  = $signed({2'b00, x_q});
    assign w_pos_y  = $signed({2'b00, y_q});

    function automatic logic [COORD_W-1:0] clamp(input logic signed [PW-1:0] v,
                                                 input int                   vmax);
        if (v < 0) begin
            return '0;
        end
        if (v > PW'(vmax)) begin
            return COORD_W'(vmax);
        end
        return v[COORD_W-1:0];
    endfunction

    logic w_tick;
    assign w_tick = (tick_q == TICK_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        tick_d       = w_tick ? '0 : tick_q + 1'b1;
        rot_cmd_d    = rot_cmd_q;
        mov_cmd_d    = mov_cmd_q;
        pending_d    = pending_q;
        x_d          = x_q;
        y_d          = y_q;
        heading_d    = heading_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        pose_valid_d = 1'b0;
        pub_x_d      = pub_x_q;
        pub_y_d      = pub_y_q;
        pub_hd_d     = pub_hd_q;
        pub_dx_d     = pub_dx_q;
        pub_dy_d     = pub_dy_q;

        case (state_q)
            ST_IDLE: begin
                // Publish the current shadow; a command tick on the same
                // edge only starts the sequence, so the snapshot is the
                // pre-update pose.
                if (frame_req || pending_q) begin
                    pose_valid_d = 1'b1;
                    pending_d    = 1'b0;
                    pub_x_d      = x_q;
                    pub_y_d      = y_q;
                    pub_hd_d     = heading_q;
                    pub_dx_d     = dir_x_q;
                    pub_dy_d     = dir_y_q;
                end
                if (w_tick && (cmd_active(rotate) || cmd_active(move))) begin
                    rot_cmd_d = rotate;
                    mov_cmd_d = move;
                    state_d   = ST_ROT;
                end
            end

            ST_ROT: begin
                // Power-of-two HEADINGS: the natural wrap gives the modulo
                if (rot_cmd_q == ROT_CCW) begin
                    heading_d = heading_q + 1'b1;
                end else if (rot_cmd_q == ROT_CW) begin
                    heading_d = heading_q - 1'b1;
                end
                state_d = ST_LOOKUP;
            end

            ST_LOOKUP: begin
                dir_x_d = w_rom_cos;
                dir_y_d = w_rom_sin;
                state_d = ST_MOVE;
            end

            default: begin // ST_MOVE
                if (mov_cmd_q == MOVE_FWD) begin
                    x_d = clamp(w_pos_x + w_step_x, X_MAX);
                    y_d = clamp(w_pos_y + w_step_y, Y_MAX);
                end else if (mov_cmd_q == MOVE_BWD) begin
                    x_d = clamp(w_pos_x - w_step_x, X_MAX);
                    y_d = clamp(w_pos_y - w_step_y, Y_MAX);
                end
                state_d = ST_IDLE;
            end
        endcase

        // A frame boundary while busy is remembered and served on return
        if ((state_q != ST_IDLE) && frame_req) begin
            pending_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            rot_cmd_q    <= 2'b00;
            mov_cmd_q    <= 2'b00;
            pending_q    <= 1'b0;
            x_q          <= COORD_W'(X_INIT);
            y_q          <= COORD_W'(Y_INIT);
            heading_q    <= '0;
            dir_x_q      <= DIR_UNIT;
            dir_y_q      <= '0;
            pose_valid_q <= 1'b0;
            pub_x_q      <= COORD_W'(X_INIT);
            pub_y_q      <= COORD_W'(Y_INIT);
            pub_hd_q     <= '0;
            pub_dx_q     <= DIR_UNIT;
            pub_dy_q     <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            rot_cmd_q    <= rot_cmd_d;
            mov_cmd_q    <= mov_cmd_d;
            pending_q    <= pending_d;
            x_q          <= x_d;
            y_q          <= y_d;
            heading_q    <= heading_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            pose_valid_q <= pose_valid_d;
            pub_x_q      <= pub_x_d;
            pub_y_q      <= pub_y_d;
            pub_hd_q     <= pub_hd_d;
            pub_dx_q     <= pub_dx_d;
            pub_dy_q     <= pub_dy_d;
        end
    end

    assign pose_valid  = pose_valid_q;
    assign pub_x       = pub_x_q;
    assign pub_y       = pub_y_q;
    assign pub_h       = H_W'(H_INIT);   // height is fixed per build
    assign pub_heading = pub_hd_q;
    assign pub_dir_x   = pub_dx_q;
    assign pub_dir_y   = pub_dy_q;

endmodule : camera_host
`default_nettype wire

// File: doc/camera_host.md
# camera_host

Parametrised camera/player pose host for the ray-tracing pipeline. Rate-samples the rotate/move controls, steps a quantised heading, and looks up its direction vector from a ROM. Moves the player along that vector with bounds clamping. Publishes a frame-stable pose snapshot to the renderer only at frame boundaries, so the pose never changes mid-frame.

## Interface

Parameters:
- COORD_W, 10: unsigned width of player x/y.
- H_W, 8: width of player height (constant per build).
- DIR_W, 8: signed width of direction components; unit length = 2^(DIR_W-2).
- HEADINGS, 16: number of quantised headings; power of 2, ≥4.
- SPEED, 4: move distance per step, in coordinate units.
- TICK_DIV, 8: clk cycles per control sample; must be ≥4.
- X_MAX, 1023: upper clamp for x. Y_MAX, 767: upper clamp for y.
- X_INIT, 512; Y_INIT, 384; H_INIT, 64: reset pose.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rotate  in  2  01 = counter-clockwise (+1 heading), 10 = clockwise (−1); 00/11 = none.
- move  in  2  01 = backward, 10 = forward; 00/11 = none.
- frame_req  in  1  single-cycle pulse from the renderer at a frame boundary.
- pose_valid  out  1  one-cycle pulse when published outputs update.
- pub_x  out  COORD_W  published x.
- pub_y  out  COORD_W  published y.
- pub_h  out  H_W  published height (= H_INIT).
- pub_dir_x  out  DIR_W  published direction x, signed.
- pub_dir_y  out  DIR_W  published direction y, signed.
- pub_heading  out  log2(HEADINGS)  published heading index.

## Operation

- Shadow pose (x, y, heading, dir) is updated by the FSM; published regs copy the shadow only on publish.
- Tick counter counts 0..TICK_DIV−1 and wraps. Controls are sampled only on the terminal-count cycle.
- FSM states: IDLE, ROT, LOOKUP, MOVE.
  - IDLE → ROT on tick with rotate or move active; otherwise stays IDLE.
  - ROT: heading ±1, modulo HEADINGS (15+1→0, 0−1→15). No change if rotate is inactive. Always → LOOKUP.
  - LOOKUP: ROM read at the new heading; dir regs load. Always → MOVE.
  - MOVE: if move is active, pos ± (dir·SPEED) >>> (DIR_W−2), using arithmetic shift (floor). → IDLE.
- Move and rotate sampled on the same tick: rotation first; movement uses the post-rotation direction.
- Sampled rotate/move values are held in a register for the whole sequence; input changes after sampling are ignored.
- Position math is done at COORD_W+2 signed. A result <0 clamps to 0; a result >X_MAX (or Y_MAX) clamps to the max.
- Publish on frame_req when the FSM is IDLE. If frame_req arrives while the FSM is busy, set `pending`; publish on the first cycle back in IDLE, then clear `pending`.
- frame_req in IDLE on the same cycle as a command tick: publish the pre-update shadow and enter ROT, both on the same edge.
- Reset values: shadow and published pose are (X_INIT, Y_INIT, H_INIT), heading 0, dir = (2^(DIR_W−2), 0). pose_valid = 0, pending = 0, state IDLE, tick counter 0.
- Reset asserted mid-sequence aborts the sequence; no partial update survives.

## Timing

- Command sampled at edge t:
  - heading valid after t+1,
  - dir valid after t+2,
  - position valid after t+3,
  - FSM back in IDLE at t+3.
- Publish latency: frame_req high in the cycle before edge t (FSM IDLE) → pub_* and pose_valid update at edge t. pose_valid is high for exactly one cycle.
- Deferred publish: takes effect at the first edge with the FSM in IDLE and `pending` set.
- TICK_DIV ≥ 4 guarantees the sequence finishes before the next sample; a tick is never dropped.
- ROM is synchronous with 1-cycle read latency.

## Structure

- Package camera_pkg holds:
  - the state enum (IDLE/ROT/LOOKUP/MOVE),
  - the pose struct typedef (x, y, h, heading, dir_x, dir_y),
  - encodings for rotate/move,
  - default parameter constants.
- Sub-module heading_rom: registered cos/sin table with HEADINGS entries of DIR_W bits, values round(2^(DIR_W−2)·cos/sin(2πk/HEADINGS)).

## Test plan

- Reset, then frame_req → pose_valid at the next edge; pub = (512, 384, 64), heading 0, dir (64, 0).
- Forward held for 3 ticks at heading 0, then frame_req → pub_x = 524, pub_y = 384.
- rotate=01 with move=10 on one tick, heading 2 → heading 3. Then verify the 45° case: from heading 1, rotate to 2 while moving forward → dir (45, 45), x and y each +2 ((45·4)>>>6).
- Heading 8, x = 2, forward → x clamps to 0. Heading 0, x = 1022, forward → x clamps to 1023.
- rotate=10 at heading 0 → heading 15. Eight further CCW steps from 15 → heading 7 (wrap).
- frame_req during LOOKUP → no publish until the FSM returns to IDLE; then a single pose_valid pulse with the post-move pose. Reset asserted during MOVE → all outputs return to reset values at once.
